// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: access widths,
// FSM states and the latched request record.
package dmem_responder_pkg;

  localparam logic [1:0] MEMW_BYTE = 2'b00;
  localparam logic [1:0] MEMW_HALF = 2'b01;
  localparam logic [1:0] MEMW_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        zext;
    logic [1:0]  width;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store request/response bundle between the hart (master) and the
// data-memory responder (slave).
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic        req_zext;
  logic [1:0]  req_width;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_zext, req_width, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_zext, req_width, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend, store byte-enable and merge,
// plus width legality and alignment check.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic        i_zext,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wrep;

  always_comb begin
    o_misalign = 1'b0;
    o_rdata    = '0;
    o_be       = '0;
    w_wrep     = i_wdata;
    w_byte     = i_rword[{i_lane, 3'b000} +: 8];
    w_half     = i_rword[{i_lane[1], 4'b0000} +: 16];
    unique case (i_width)
      MEMW_BYTE: begin
        o_rdata = {{24{~i_zext & w_byte[7]}}, w_byte};
        o_be    = 4'b0001 << i_lane;
        w_wrep  = {4{i_wdata[7:0]}};
      end
      MEMW_HALF: begin
        o_misalign = i_lane[0];
        o_rdata    = {{16{~i_zext & w_half[15]}}, w_half};
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep     = {2{i_wdata[15:0]}};
      end
      MEMW_WORD: begin
        o_misalign = |i_lane;
        o_rdata    = i_rword;
        o_be       = 4'b1111;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  // Replicated store data lands only in enabled lanes; the rest keep the old word.
  always_comb begin
    o_wword = i_rword;
    for (int i = 0; i < 4; i++) begin
      if (o_be[i]) o_wword[8*i +: 8] = w_wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request per handshake, word-organised array,
// programmable wait states, right-aligned extended load data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned LATENCY     = 1
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave dmem
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt;
  mem_req_t    r_req;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  mem_req_t    w_bus_req, w_acc;
  logic        w_accept, w_enter_resp;
  logic [31:0] w_off, w_word_idx;
  logic [AW-1:0] w_idx;
  logic        w_oor, w_misalign, w_err;
  logic [31:0] w_rword, w_load, w_wword;
  logic [3:0]  w_be;

  assign w_bus_req = '{addr: dmem.req_addr, we: dmem.req_we, zext: dmem.req_zext,
                       width: dmem.req_width, wdata: dmem.req_wdata};
  assign w_accept  = dmem.req_valid && dmem.req_ready;

  // With zero wait states the access happens on the accept edge, so use the live bus.
  assign w_acc      = (r_state == StIdle) ? w_bus_req : r_req;
  assign w_off      = w_acc.addr - BASE_ADDR;
  assign w_word_idx = {2'b00, w_off[31:2]};
  assign w_idx      = w_off[AW+1:2];
  assign w_oor      = w_word_idx >= DEPTH_WORDS;
  assign w_rword    = w_oor ? '0 : r_mem[w_idx];
  assign w_err      = w_oor || w_misalign;

  dmem_lane_align u_lane_align (
    .i_width    (w_acc.width),
    .i_zext     (w_acc.zext),
    .i_lane     (w_off[1:0]),
    .i_rword    (w_rword),
    .i_wdata    (w_acc.wdata),
    .o_misalign (w_misalign),
    .o_rdata    (w_load),
    .o_be       (w_be),
    .o_wword    (w_wword)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_d = (LATENCY == 0) ? StResp : StWait;
      StWait: if (r_cnt == 4'd1) w_state_d = StResp;
      StResp: if (dmem.rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    dmem.req_ready = (r_state == StIdle) && !reset;
    dmem.rsp_valid = (r_state == StResp);
    dmem.rsp_rdata = r_rdata;
    dmem.rsp_err   = r_err;
  end

  assign w_enter_resp = (w_state_d == StResp) && (r_state != StResp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req <= w_bus_req;
        r_cnt <= 4'(LATENCY);
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_acc.we || w_err) ? '0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  // Array contents survive reset; stores commit only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc.we && !w_err && (w_be != 4'b0000)) r_mem[w_idx] <= w_wword;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 3, 0) share
// stimulus; a select picks which one is driven and observed.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst, rst3x;
  logic [1:0] sel;
  logic        t_req_valid, t_we, t_zext, t_rsp_ready;
  logic [1:0]  t_width;
  logic [31:0] t_addr, t_wdata;
  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_if b0 ();
  dmem_if b1 ();
  dmem_if b3 ();

  assign b0.req_valid = t_req_valid && (sel == 2'd0);
  assign b1.req_valid = t_req_valid && (sel == 2'd1);
  assign b3.req_valid = t_req_valid && (sel == 2'd3);
  assign b0.rsp_ready = t_rsp_ready && (sel == 2'd0);
  assign b1.rsp_ready = t_rsp_ready && (sel == 2'd1);
  assign b3.rsp_ready = t_rsp_ready && (sel == 2'd3);
  assign b0.req_addr = t_addr;  assign b1.req_addr = t_addr;  assign b3.req_addr = t_addr;
  assign b0.req_we = t_we;      assign b1.req_we = t_we;      assign b3.req_we = t_we;
  assign b0.req_zext = t_zext;  assign b1.req_zext = t_zext;  assign b3.req_zext = t_zext;
  assign b0.req_width = t_width; assign b1.req_width = t_width; assign b3.req_width = t_width;
  assign b0.req_wdata = t_wdata; assign b1.req_wdata = t_wdata; assign b3.req_wdata = t_wdata;

  always_comb begin
    m_req_ready = b1.req_ready;
    m_rsp_valid = b1.rsp_valid;
    m_rsp_rdata = b1.rsp_rdata;
    m_rsp_err   = b1.rsp_err;
    if (sel == 2'd0) begin
      m_req_ready = b0.req_ready; m_rsp_valid = b0.rsp_valid;
      m_rsp_rdata = b0.rsp_rdata; m_rsp_err = b0.rsp_err;
    end else if (sel == 2'd3) begin
      m_req_ready = b3.req_ready; m_rsp_valid = b3.rsp_valid;
      m_rsp_rdata = b3.rsp_rdata; m_rsp_err = b3.rsp_err;
    end
  end

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(0), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst), .dmem(b0.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(0), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst), .dmem(b1.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(0), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst | rst3x), .dmem(b3.slave));

  // Issue one request on the selected instance; lat counts cycles from accept to rsp_valid.
  task automatic do_req(input logic [31:0] a, input logic we, input logic zx,
                        input logic [1:0] w, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    t_addr = a; t_we = we; t_zext = zx; t_width = w; t_wdata = wd; t_req_valid = 1'b1;
    while (!m_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = m_rsp_rdata; er = m_rsp_err;
    t_rsp_ready = 1'b1; @(posedge clk); #1; t_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel = 2'd1; rst = 1'b1; rst3x = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (m_req_ready !== 1'b0) begin n_errors++;
      $display("FAIL reset_req_ready: got %b expected 0", m_req_ready); end
    n_checks++; if ({m_rsp_valid, m_rsp_err, m_rsp_rdata} !== 34'h0) begin n_errors++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h expected 0", m_rsp_valid, m_rsp_err,
               m_rsp_rdata); end
    rst = 1'b0; #1;
    n_checks++; if (m_req_ready !== 1'b1) begin n_errors++;
      $display("FAIL post_reset_req_ready: got %b expected 1", m_req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h10, 1'b1, 1'b0, 2'b10, 32'hDEADBEEF, rd, er, lat);
    n_checks++; if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin n_errors++;
      $display("FAIL store_word: got lat=%0d d=%h e=%b expected lat=2 d=0 e=0", lat, rd, er); end
    do_req(32'h10, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin n_errors++;
      $display("FAIL load_word: got lat=%0d d=%h e=%b expected lat=2 d=deadbeef e=0",
               lat, rd, er); end
  endtask

  task automatic test_load_extend();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic        zx    [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  wd    [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] exp   [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'hFFFFFFEF,
                               32'h0000BEEF};
    for (int i = 0; i < 5; i++) begin
      do_req(addrs[i], 1'b0, zx[i], wd[i], 32'h0, rd, er, lat);
      n_checks++; if (rd !== exp[i] || er !== 1'b0) begin n_errors++;
        $display("FAIL load_ext[%0d]: got d=%h e=%b expected d=%h e=0", i, rd, er, exp[i]); end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd; logic er; int lat;
    do_req(32'h11, 1'b1, 1'b0, 2'b00, 32'hAABBCC55, rd, er, lat);
    do_req(32'h10, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_errors++;
      $display("FAIL store_byte: got %h expected dead55ef", rd); end
    do_req(32'h14, 1'b1, 1'b0, 2'b10, 32'h11223344, rd, er, lat);
    do_req(32'h16, 1'b1, 1'b0, 2'b01, 32'hABCD1234, rd, er, lat);
    do_req(32'h14, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h12343344) begin n_errors++;
      $display("FAIL store_half: got %h expected 12343344", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [5] = '{32'h11, 32'h12, 32'h10, 32'h1000, 32'h13};
    logic        wes   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  wd    [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      do_req(addrs[i], wes[i], 1'b0, wd[i], 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'h0 || er !== 1'b1) begin n_errors++;
        $display("FAIL error[%0d]: got d=%h e=%b expected d=0 e=1", i, rd, er); end
    end
    do_req(32'h10, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEAD55EF || er !== 1'b0) begin n_errors++;
      $display("FAIL error_no_write: got d=%h e=%b expected dead55ef e=0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    int guard = 0;
    t_addr = 32'h10; t_we = 1'b0; t_zext = 1'b0; t_width = 2'b10; t_req_valid = 1'b1;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    while (!m_rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    // A competing store presented while the response is stalled must be ignored.
    t_req_valid = 1'b1; t_we = 1'b1; t_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== 32'hDEAD55EF || m_req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall[%0d]: got v=%b d=%h rdy=%b expected v=1 d=dead55ef rdy=0",
                 i, m_rsp_valid, m_rsp_rdata, m_req_ready);
      end
      @(posedge clk); #1;
    end
    t_req_valid = 1'b0; t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
    n_checks++; if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b1) begin n_errors++;
      $display("FAIL stall_release: got v=%b rdy=%b expected v=0 rdy=1", m_rsp_valid,
               m_req_ready); end
    do_req(32'h10, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_errors++;
      $display("FAIL stall_ignored_req: got %h expected dead55ef", rd); end
  endtask

  task automatic test_lat3_reset();
    logic [31:0] rd; logic er; int lat;
    sel = 2'd3;
    do_req(32'h20, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, rd, er, lat);
    do_req(32'h20, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (lat !== 4 || rd !== 32'hCAFEF00D) begin n_errors++;
      $display("FAIL lat3_load: got lat=%0d d=%h expected lat=4 d=cafef00d", lat, rd); end
    t_addr = 32'h20; t_we = 1'b1; t_width = 2'b10; t_wdata = 32'h0; t_req_valid = 1'b1;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    @(posedge clk); #1;
    rst3x = 1'b1; #1;
    n_checks++;
    if ({m_rsp_valid, m_req_ready, m_rsp_err} !== 3'b000 || m_rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL lat3_mid_reset: got v=%b rdy=%b e=%b d=%h expected all 0",
               m_rsp_valid, m_req_ready, m_rsp_err, m_rsp_rdata);
    end
    @(posedge clk); #1;
    rst3x = 1'b0;
    @(posedge clk); #1;
    do_req(32'h20, 1'b0, 1'b0, 2'b10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_errors++;
      $display("FAIL lat3_store_dropped: got %h expected cafef00d", rd); end
  endtask

  task automatic test_lat0();
    logic [31:0] rd; logic er; int lat;
    sel = 2'd0;
    do_req(32'h8, 1'b1, 1'b0, 2'b10, 32'h0BADCAFE, rd, er, lat);
    n_checks++; if (lat !== 1 || er !== 1'b0) begin n_errors++;
      $display("FAIL lat0_store: got lat=%0d e=%b expected lat=1 e=0", lat, er); end
    do_req(32'hA, 1'b0, 1'b1, 2'b01, 32'h0, rd, er, lat);
    n_checks++; if (lat !== 1 || rd !== 32'h00000BAD) begin n_errors++;
      $display("FAIL lat0_load: got lat=%0d d=%h expected lat=1 d=00000bad", lat, rd); end
  endtask

  initial begin
    t_req_valid = 1'b0; t_we = 1'b0; t_zext = 1'b0; t_rsp_ready = 1'b0;
    t_width = 2'b10; t_addr = '0; t_wdata = '0;
    test_reset();
    test_word();
    test_load_extend();
    test_store_lanes();
    test_errors();
    test_backpressure();
    test_lat3_reset();
    test_lat0();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
